sprite_anim_ctrl: RTL and testbench

Parametrised draw/wait/erase animation sequencer for one rectangular sprite on the VGA framebuffer path. It steps through every sprite pixel with a plot strobe, holds for a programmable wait, then erases at the same position. Key-driven horizontal moves are committed only between frames. Moves saturate at the screen bounds and never wrap. It drives the existing pixel-writer datapath through op/plot/x/offset outputs.

---
 rtl/sprite_anim_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_sprite_anim_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_ctrl.sv
// sprite_anim_ctrl: draw / wait / erase sequencer for one rectangular sprite.
// Each frame walks every sprite pixel with op=draw, idles for WAIT_CYCLES,
// then walks the same pixels with op=erase. Key presses queue one horizontal
// move, which is applied to x only on the last erase pixel, so a frame is
// always erased at the position it was drawn at.
// Optional build macro: AUTO_MOVE_EN adds a bouncing auto-move direction.
//
// Handshake: there is no valid/ready pair. plot is a one-cycle-per-pixel
// write strobe with op/x/px_dx/px_dy valid in the same cycle; the pixel
// writer is expected to accept every strobe.
// The FSM state is visible on op, whose encoding equals the state encoding.
module sprite_anim_ctrl #(
  parameter int XW          = 8,
  parameter int SPR_W       = 5,
  parameter int SPR_H       = 5,
  parameter int WAIT_CYCLES = 25,
  parameter int X_INIT      = 0,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 155,
  parameter int STEP        = 1,
  localparam int DXW = (SPR_W > 1) ? $clog2(SPR_W) : 1,
  localparam int DYW = (SPR_H > 1) ? $clog2(SPR_H) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           enable,
  input  logic [3:0]     KEY,
  output logic [1:0]     op,
  output logic           plot,
  output logic [XW-1:0]  x,
  output logic [DXW-1:0] px_dx,
  output logic [DYW-1:0] px_dy,
  output logic           frame_done
);

  localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  // State encoding doubles as the op code driven to the pixel writer.
  typedef enum logic [1:0] {
    S_DRAW  = 2'b00,
    S_ERASE = 2'b01,
    S_WAIT  = 2'b10,
    S_IDLE  = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    MV_NONE  = 2'b00,
    MV_RIGHT = 2'b01,
    MV_LEFT  = 2'b10
  } move_t;

  state_t         state, state_nx;
  move_t          pending, pend_nx;
  logic [DXW-1:0] dx;
  logic [DYW-1:0] dy;
  logic [WW-1:0]  wait_cnt;
  logic [XW-1:0]  x_nx;
  logic [1:0]     key_s1, key_s2, key_d, key_fall;
  logic           walking, dx_last, pix_last, wait_last, commit;
  logic [XW:0]    x_up, x_dn;
  logic [XW-1:0]  x_right, x_left;
  logic           unused_key;

  assign unused_key = ^KEY[3:2];

  assign walking   = (state == S_DRAW) || (state == S_ERASE);
  assign dx_last   = (dx == DXW'(SPR_W - 1));
  assign pix_last  = dx_last && (dy == DYW'(SPR_H - 1));
  assign wait_last = (wait_cnt == WW'(WAIT_CYCLES - 1));
  assign commit    = (state == S_ERASE) && pix_last;

  // Saturating moves computed one bit wider; x_dn[XW] is the borrow.
  assign x_up    = {1'b0, x} + (XW+1)'(STEP);
  assign x_dn    = {1'b0, x} - (XW+1)'(STEP);
  assign x_right = (x_up > (XW+1)'(X_MAX)) ? XW'(X_MAX) : x_up[XW-1:0];
  assign x_left  = (x_dn[XW] || (x_dn < (XW+1)'(X_MIN))) ? XW'(X_MIN) : x_dn[XW-1:0];

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic: a frame always runs to completion once started.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (enable)    state_nx = S_DRAW;
      S_DRAW:  if (pix_last)  state_nx = S_WAIT;
      S_WAIT:  if (wait_last) state_nx = S_ERASE;
      S_ERASE: if (pix_last)  state_nx = enable ? S_DRAW : S_IDLE;
      default:                state_nx = S_IDLE;
    endcase
  end

  // Output decode, purely from registered state and counters.
  always_comb begin
    op         = state;
    plot       = walking;
    px_dx      = dx;
    px_dy      = dy;
    frame_done = commit;
  end

  // Row-major pixel walk counters and the wait counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dx       <= '0;
      dy       <= '0;
      wait_cnt <= '0;
    end else begin
      if (walking) begin
        if (dx_last) begin
          dx <= '0;
          dy <= pix_last ? '0 : dy + 1'b1;
        end else begin
          dx <= dx + 1'b1;
        end
      end else begin
        dx <= '0;
        dy <= '0;
      end
      if (state == S_WAIT) wait_cnt <= wait_last ? '0 : wait_cnt + 1'b1;
      else                 wait_cnt <= '0;
    end
  end

  // Two-flop synchroniser plus previous-value flop for falling-edge detect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_s1 <= 2'b11;
      key_s2 <= 2'b11;
      key_d  <= 2'b11;
    end else begin
      key_s1 <= KEY[1:0];
      key_s2 <= key_s1;
      key_d  <= key_s2;
    end
  end

  assign key_fall = key_d & ~key_s2;

  // Pending move: latest edge wins, simultaneous left+right cancels.
  always_comb begin
    pend_nx = pending;
    if (commit) pend_nx = MV_NONE;
    if (key_fall == 2'b11)  pend_nx = MV_NONE;
    else if (key_fall[0])   pend_nx = MV_RIGHT;
    else if (key_fall[1])   pend_nx = MV_LEFT;
  end

  // Pending move register and committed x.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= MV_NONE;
      x       <= XW'(X_INIT);
    end else begin
      pending <= pend_nx;
      x       <= x_nx;
    end
  end

`ifdef AUTO_MOVE_EN
  logic dir, dir_nx;  // 1 = moving right

  // Commit: key move wins and sets direction; otherwise bounce between bounds.
  always_comb begin
    x_nx   = x;
    dir_nx = dir;
    if (commit) begin
      case (pending)
        MV_RIGHT: begin x_nx = x_right; dir_nx = 1'b1; end
        MV_LEFT:  begin x_nx = x_left;  dir_nx = 1'b0; end
        default: begin
          if (dir) begin
            x_nx = x_right;
            if (x_right == XW'(X_MAX)) dir_nx = 1'b0;
          end else begin
            x_nx = x_left;
            if (x_left == XW'(X_MIN)) dir_nx = 1'b1;
          end
        end
      endcase
    end
  end

  // Auto-move direction register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dir <= 1'b1;
    else          dir <= dir_nx;
  end
`else
  // Commit: apply the pending key move; with none pending x holds.
  always_comb begin
    x_nx = x;
    if (commit) begin
      case (pending)
        MV_RIGHT: x_nx = x_right;
        MV_LEFT:  x_nx = x_left;
        default:  x_nx = x;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// tb_sprite_anim_ctrl: directed frame-level checks of sprite_anim_ctrl with
// default parameters (5x5 sprite, 25 wait cycles, x in 0..155).
`timescale 1ns/1ps
module tb_sprite_anim_ctrl;

  localparam int XW    = 8;
  localparam int SW    = 5;
  localparam int SH    = 5;
  localparam int WC    = 25;
  localparam int FRAME = 2*SW*SH + WC;
  localparam int XMAX  = 155;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [3:0]    KEY;
  logic [1:0]    op;
  logic          plot;
  logic [XW-1:0] x;
  logic [2:0]    px_dx;
  logic [2:0]    px_dy;
  logic          frame_done;

  always #5 clk = ~clk;

  sprite_anim_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .KEY        (KEY),
    .op         (op),
    .plot       (plot),
    .x          (x),
    .px_dx      (px_dx),
    .px_dy      (px_dy),
    .frame_done (frame_done)
  );

  // ---------------- tables ----------------
  typedef struct {
    string      name;
    int         n;
    logic [1:0] op;
    logic       plot;
    logic       walk;
  } seg_t;

  // ka/kb: KEY value driven for 2 cycles starting at frame cycle ta/tb (-1 = none)
  // en_off: frame cycle after which enable drops; rst_at: cycle after which reset asserts
  typedef struct {
    string         name;
    logic [3:0]    ka;
    int            ta;
    logic [3:0]    kb;
    int            tb;
    logic [XW-1:0] ex;
    int            en_off;
    int            rst_at;
  } frame_t;

  seg_t          segs[3];
  frame_t        tbl[7];
  logic [XW-1:0] exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- scoreboard ----------------
  function automatic logic [17:0] obs();
    return {op, plot, px_dx, px_dy, frame_done, x};
  endfunction

  task automatic check(input string name, input int c, input logic [17:0] got, input logic [17:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s c=%0d got op=%b plot=%b dx=%0d dy=%0d fd=%b x=%0d want op=%b plot=%b dx=%0d dy=%0d fd=%b x=%0d",
               name, c, got[17:16], got[15], got[14:12], got[11:9], got[8], got[7:0],
               want[17:16], want[15], want[14:12], want[11:9], want[8], want[7:0]);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name, input logic [XW-1:0] ex);
    check(name, -1, obs(), {2'b11, 1'b0, 3'd0, 3'd0, 1'b0, ex});
  endtask

  task automatic run_frame(input frame_t f);
    int            s;
    int            k;
    logic [2:0]    e_dx;
    logic [2:0]    e_dy;
    logic          e_fd;
    for (int c = 0; c < FRAME; c++) begin
      step();
      s = 0;
      k = c;
      while (s < 2 && k >= segs[s].n) begin
        k -= segs[s].n;
        s++;
      end
      e_dx = segs[s].walk ? 3'(k % SW) : 3'd0;
      e_dy = segs[s].walk ? 3'(k / SW) : 3'd0;
      e_fd = (s == 2) && (k == segs[2].n - 1);
      check(f.name, c, obs(), {segs[s].op, segs[s].plot, e_dx, e_dy, e_fd, f.ex});
      if (f.ta >= 0 && c == f.ta + 2) KEY = 4'hF;
      if (f.tb >= 0 && c == f.tb + 2) KEY = 4'hF;
      if (c == f.ta) KEY = f.ka;
      if (c == f.tb) KEY = f.kb;
      if (c == f.en_off) enable = 1'b0;
      if (c == f.rst_at) begin
        reset_n = 1'b0;
        #1;
        check_idle({f.name, "_async_reset"}, XW'(0));
        return;
      end
    end
  endtask

  // ---------------- test ----------------
  initial begin
    frame_t        f;
    logic [XW-1:0] x_drop;
    logic [XW-1:0] x_after;

    segs[0] = '{"draw",  SW*SH, 2'b00, 1'b1, 1'b1};
    segs[1] = '{"wait",  WC,    2'b10, 1'b0, 1'b0};
    segs[2] = '{"erase", SW*SH, 2'b01, 1'b1, 1'b1};

    tbl[0] = '{"f0_right_in_wait",      4'hE,  30, 4'hF, -1, 8'd0, -1, -1};
    tbl[1] = '{"f1_right_then_left",    4'hE,   2, 4'hD, 30, 8'd1, -1, -1};
    tbl[2] = '{"f2_left_at_min",        4'hD,  30, 4'hF, -1, 8'd0, -1, -1};
    tbl[3] = '{"f3_right_then_both",    4'hE,   2, 4'hC, 30, 8'd0, -1, -1};
    tbl[4] = '{"f4_right_in_commit",    4'hE,  72, 4'hF, -1, 8'd0, -1, -1};
    tbl[5] = '{"f5_commit_late_edge",   4'hF,  -1, 4'hF, -1, 8'd0, -1, -1};
    tbl[6] = '{"f6_no_pending",         4'hF,  -1, 4'hF, -1, 8'd1, -1, -1};

    reset_n = 1'b0;
    enable  = 1'b0;
    KEY     = 4'hF;
    repeat (3) step();
    check_idle("reset_state", XW'(0));

    reset_n = 1'b1;
    enable  = 1'b1;
    check_idle("idle_after_release", XW'(0));

`ifndef AUTO_MOVE_EN
    foreach (tbl[i]) run_frame(tbl[i]);

    // Climb to the right edge with one press per frame, then push past it.
    for (int j = 0; j <= XMAX; j++) exp_q.push_back(XW'((1 + j > XMAX) ? XMAX : 1 + j));
    while (exp_q.size() > 0) begin
      f = '{"climb_right", 4'hE, 30, 4'hF, -1, exp_q.pop_front(), -1, -1};
      run_frame(f);
    end
    x_drop  = XW'(XMAX);
    x_after = XW'(XMAX);
`else
    // Free-running bounce: 0,1,...,155,154.
    for (int j = 0; j <= XMAX + 1; j++) exp_q.push_back(XW'((j <= XMAX) ? j : 2*XMAX - j));
    while (exp_q.size() > 0) begin
      f = '{"auto_bounce", 4'hF, -1, 4'hF, -1, exp_q.pop_front(), -1, -1};
      run_frame(f);
    end
    x_drop  = XW'(XMAX - 2);
    x_after = XW'(XMAX - 3);
`endif

    // Enable dropped mid-draw: frame completes, then parks in idle.
    f = '{"enable_drop", 4'hF, -1, 4'hF, -1, x_drop, 10, -1};
    run_frame(f);
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("parked_idle", x_after);
    end

    // Restart from idle, then reset in the middle of erase.
    enable = 1'b1;
    f = '{"restart_then_reset", 4'hF, -1, 4'hF, -1, x_after, -1, 60};
    run_frame(f);
    step();
    check_idle("held_in_reset", XW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
